uart_tx_fifo: RTL and testbench

//  Byte FIFO that sits directly upstream of UART_driver and feeds its transmit side.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmit driver through a Start/Ready handshake.
// Optional drop counter: define UART_TX_FIFO_DROP_CNT_EN to add drop_cnt/drop_clr.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          UART_Ready,
    output logic          UART_Start,
    output logic [7:0]    data_out
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt,
    input  logic          drop_clr
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [7:0]    mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          almost_full_reg;
    logic          empty_reg;
    logic          overflow_reg;
    logic [1:0]    state_reg;
    logic [1:0]    ack_cnt_reg;
    logic          start_reg;
    logic [7:0]    data_out_reg;
    logic          push;
    logic          pop;

    // Full is the registered pre-pop value, so a push into a full FIFO is
    // rejected even when a pop happens on the same edge.
    assign push = wr_en && !full_reg;
    assign pop  = (state_reg == IDLE) && !empty_reg && UART_Ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            empty_reg       <= 1'b1;
            overflow_reg    <= 1'b0;
            state_reg       <= IDLE;
            ack_cnt_reg     <= '0;
            start_reg       <= 1'b0;
            data_out_reg    <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg       <= count_next;
            full_reg        <= (count_next == DEPTH_C);
            almost_full_reg <= (count_next >= AFULL_C);
            empty_reg       <= (count_next == '0);
            overflow_reg    <= wr_en && full_reg;

            case (state_reg)
                IDLE: begin
                    start_reg <= 1'b0;
                    if (pop) begin
                        data_out_reg <= mem_reg[rd_ptr_reg];
                        start_reg    <= 1'b1;
                        ack_cnt_reg  <= '0;
                        state_reg    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Ready dropping is the driver's acknowledge; if it never
                    // comes, re-launch the same byte every fourth cycle.
                    if (!UART_Ready) begin
                        start_reg <= 1'b0;
                        state_reg <= WAIT_DONE;
                    end else if (ack_cnt_reg == 2'd3) begin
                        start_reg   <= 1'b1;
                        ack_cnt_reg <= '0;
                    end else begin
                        start_reg   <= 1'b0;
                        ack_cnt_reg <= ack_cnt_reg + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    start_reg <= 1'b0;
                    if (UART_Ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    start_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop_clr) begin
            drop_cnt_reg <= '0;
        end else if (wr_en && full_reg && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign empty       = empty_reg;
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign UART_Start  = start_reg;
    assign data_out    = data_out_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based byte-stream model plus
// a behavioural UART driver (Ready low after Start, high again 10 cycles later).
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          UART_Ready;
    logic          UART_Start;
    logic [7:0]    data_out;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [15:0]   drop_cnt;
    logic          drop_clr = 1'b0;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .UART_Ready  (UART_Ready),
        .UART_Start  (UART_Start),
        .data_out    (data_out)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt),
        .drop_clr    (drop_clr)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready is either driven by hand or by the driver model
    logic man_ready = 1'b1;
    logic drv_ready = 1'b1;
    bit   drv_en    = 1'b0;
    int   drv_busy  = 0;

    assign UART_Ready = drv_en ? drv_ready : man_ready;

    always @(negedge clk) begin
        if (!drv_en) begin
            drv_ready = 1'b1;
            drv_busy  = 0;
        end else if (drv_busy > 0) begin
            drv_busy = drv_busy - 1;
            if (drv_busy == 0) drv_ready = 1'b1;
        end else if (UART_Start) begin
            drv_ready = 1'b0;
            drv_busy  = 10;
        end
    end

    // Monitor: every Start pulse is one launched byte
    bit          mon_en = 1'b0;
    bit          ovf_seen = 1'b0;
    logic [7:0]  got_q[$];
    int unsigned got_cyc[$];
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        if (mon_en && UART_Start) begin
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
        end
        if (overflow) ovf_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (got_q.size() < n) begin
            n_fail++;
            $display("FAIL wait_got: got %0d Start pulses, required %0d within %0d cycles",
                     got_q.size(), n, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({empty, full, almost_full, overflow, UART_Start} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: e/f/af/ovf/start=%b required 10000",
                     {empty, full, almost_full, overflow, UART_Start});
        end
        n_tests++;
        if (count !== CW'(0) || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: count=%0d data_out=%h required 0/00", count, data_out);
        end
`ifdef UART_TX_FIFO_DROP_CNT_EN
        n_tests++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: %0d required 0", drop_cnt);
        end
`endif
        rst = 1'b0;
        tick();
        $display("[TB] reset done");
    endtask

    task automatic test_single();
        man_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (count !== CW'(1) || empty !== 1'b0 || UART_Start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push: count=%0d empty=%b start=%b required 1/0/0",
                     count, empty, UART_Start);
        end
        tick();
        n_tests++;
        if (UART_Start !== 1'b1 || data_out !== 8'hA5 || empty !== 1'b1 || count !== CW'(0)) begin
            n_fail++;
            $display("FAIL single_start: start=%b data=%h empty=%b count=%0d required 1/a5/1/0",
                     UART_Start, data_out, empty, count);
        end
        man_ready = 1'b0;
        tick();
        n_tests++;
        if (UART_Start !== 1'b0 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_pulse: start=%b data=%h required 0/a5", UART_Start, data_out);
        end
        man_ready = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (UART_Start !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: start=%b empty=%b required 0/1", UART_Start, empty);
        end
        $display("[TB] single byte a5 sent");
    endtask

    task automatic test_fill();
        man_ready = 1'b0;
        exp_q.delete();
        for (int k = 1; k <= DEPTH; k++) begin
            wr_en = 1'b1;
            wr_data = 8'(k - 1);
            exp_q.push_back(8'(k - 1));
            tick();
            n_tests++;
            if (count !== CW'(k) || almost_full !== (k >= 12) || full !== (k == DEPTH)
                || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d af=%b full=%b ovf=%b", k, count,
                         almost_full, full, overflow);
            end
        end
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_overflow: ovf=%b count=%0d required 1/16", overflow, count);
        end
        tick();
        n_tests++;
        if (overflow !== 1'b0 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_ovf_pulse: ovf=%b count=%0d required 0/16", overflow, count);
        end
        $display("[TB] filled 16 bytes, 17th rejected");
    endtask

    task automatic check_stream(input string name);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d bytes required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_tests++;
            if (got_cyc[i] - got_cyc[i-1] < 12) begin
                n_fail++;
                $display("FAIL %s_gap%0d: %0d cycles required >= 12", name, i,
                         got_cyc[i] - got_cyc[i-1]);
            end
        end
    endtask

    task automatic test_drain();
        got_q.delete();
        got_cyc.delete();
        mon_en = 1'b1;
        drv_en = 1'b1;
        wait_got(DEPTH, 400);
        repeat (14) tick();
        mon_en = 1'b0;
        check_stream("drain");
        n_tests++;
        if (empty !== 1'b1 || count !== CW'(0) || full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: empty=%b count=%0d full=%b required 1/0/0",
                     empty, count, full);
        end
        drv_en = 1'b0;
        $display("[TB] drained %0d bytes", got_q.size());
    endtask

    task automatic test_push_pop_same();
        logic [7:0] x;
        logic [7:0] y;
        x = 8'($urandom);
        y = 8'($urandom);
        man_ready = 1'b0;
        wr_en = 1'b1;
        wr_data = x;
        tick();
        wr_data = y;
        man_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (count !== CW'(1) || UART_Start !== 1'b1 || data_out !== x) begin
            n_fail++;
            $display("FAIL pushpop_same: count=%0d start=%b data=%h required 1/1/%h",
                     count, UART_Start, data_out, x);
        end
        man_ready = 1'b0;
        tick();
        man_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (count !== CW'(0) || UART_Start !== 1'b1 || data_out !== y) begin
            n_fail++;
            $display("FAIL pushpop_second: count=%0d start=%b data=%h required 0/1/%h",
                     count, UART_Start, data_out, y);
        end
        man_ready = 1'b0;
        tick();
        man_ready = 1'b1;
        repeat (2) tick();
        $display("[TB] push+pop same edge: %h then %h", x, y);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        ovf_seen = 1'b0;
        mon_en = 1'b1;
        drv_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            wr_en = 1'b1;
            wr_data = d;
            tick();
            wr_en = 1'b0;
            repeat ($urandom_range(16, 10)) tick();
        end
        wait_got(40, 800);
        repeat (14) tick();
        mon_en = 1'b0;
        drv_en = 1'b0;
        check_stream("stream");
        n_tests++;
        if (ovf_seen || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_end: overflow_seen=%b empty=%b required 0/1", ovf_seen, empty);
        end
        $display("[TB] streamed %0d random bytes", got_q.size());
    endtask

    task automatic test_repulse();
        logic [7:0] z;
        z = 8'($urandom);
        got_q.delete();
        got_cyc.delete();
        man_ready = 1'b1;
        mon_en = 1'b1;
        wr_en = 1'b1;
        wr_data = z;
        tick();
        wr_en = 1'b0;
        repeat (14) tick();
        mon_en = 1'b0;
        n_tests++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL repulse_cnt: %0d Start pulses required 4", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== z) begin
                n_fail++;
                $display("FAIL repulse_data%0d: got %h required %h", i, got_q[i], z);
            end
            if (i > 0) begin
                n_tests++;
                if (got_cyc[i] - got_cyc[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL repulse_period%0d: %0d cycles required 4", i,
                             got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        man_ready = 1'b0;
        tick();
        man_ready = 1'b1;
        repeat (2) tick();
        n_tests++;
        if (empty !== 1'b1 || UART_Start !== 1'b0) begin
            n_fail++;
            $display("FAIL repulse_end: empty=%b start=%b required 1/0", empty, UART_Start);
        end
        $display("[TB] re-pulse of %h observed %0d times", z, got_q.size());
    endtask

`ifdef UART_TX_FIFO_DROP_CNT_EN
    task automatic test_drop_cnt();
        man_ready = 1'b0;
        wr_en = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wr_data = 8'($urandom);
            tick();
        end
        repeat (3) tick();
        wr_en = 1'b0;
        n_tests++;
        if (drop_cnt !== 16'd3 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL drop_cnt3: drop_cnt=%0d count=%0d required 3/16", drop_cnt, count);
        end
        drop_clr = 1'b1;
        wr_en = 1'b1;
        tick();
        drop_clr = 1'b0;
        wr_en = 1'b0;
        n_tests++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL drop_clr: drop_cnt=%0d required 0", drop_cnt);
        end
        $display("[TB] drop counter 3 then cleared");
    endtask
`endif

    task automatic test_reset_mid();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        man_ready = 1'b0;
        wr_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        tick();
        n_tests++;
        if (count !== CW'(5) || UART_Start !== 1'b0 || data_out === 8'hxx) begin
            n_fail++;
            $display("FAIL rstmid_setup: count=%0d start=%b required 5/0", count, UART_Start);
        end
        got_q.delete();
        mon_en = 1'b1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (UART_Start !== 1'b0 || count !== CW'(0) || empty !== 1'b1 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_async: start=%b count=%0d empty=%b data=%h required 0/0/1/00",
                     UART_Start, count, empty, data_out);
        end
        repeat (2) tick();
        rst = 1'b0;
        man_ready = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;
        n_tests++;
        if (got_q.size() != 0 || empty !== 1'b1 || count !== CW'(0)) begin
            n_fail++;
            $display("FAIL rstmid_after: starts=%0d empty=%b count=%0d required 0/1/0",
                     got_q.size(), empty, count);
        end
        $display("[TB] reset mid-transfer discarded queue");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_push_pop_same();
        test_back_to_back();
        test_repulse();
`ifdef UART_TX_FIFO_DROP_CNT_EN
        test_drop_cnt();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
